// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared definitions for the load/store unit.
// Reuses the cache write-width codes (`CACHE_D_WRITE_*) when the surrounding
// build already defines them; otherwise they are supplied here.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (see riscv_lsu_align).

`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`endif
`ifndef CACHE_D_WRITE_SW
`define CACHE_D_WRITE_SW 2'b00
`endif
`ifndef CACHE_D_WRITE_SH
`define CACHE_D_WRITE_SH 2'b01
`endif
`ifndef CACHE_D_WRITE_SB
`define CACHE_D_WRITE_SB 2'b10
`endif

package riscv_lsu_pkg;

  // LSU FSM state encodings
  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_e;

  // RV32I load/store width encodings (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Response cause codes
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  // Map a funct3 width onto the cache write-width code; anything that is
  // not a byte or half access uses the word code (also the idle value).
  function automatic logic [`CACHE_D_WRITE_LEN-1:0] write_code(input logic [2:0] f3);
    logic [`CACHE_D_WRITE_LEN-1:0] code;
    case (f3)
      F3_B, F3_BU: code = `CACHE_D_WRITE_SB;
      F3_H, F3_HU: code = `CACHE_D_WRITE_SH;
      default:     code = `CACHE_D_WRITE_SW;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: combinational datapath of the LSU.
// - store lane replication and fault classification for the incoming request
// - lane extraction and sign/zero extension for the latched load
// Misalignment trapping exists only when LSU_MISALIGN_TRAP_EN is defined;
// otherwise misaligned H/W accesses proceed and the low address bits are
// simply not used for lane selection.

module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned DMEM_SIZE_BYTES = 32'd65536
) (
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] store_data,
  output logic        fault,
  output logic [1:0]  cause,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic        illegal_s;
  logic        range_s;
  logic        misalign_s;
  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Classify the request: illegal width, out-of-range address, misalignment
  always_comb begin
    illegal_s  = 1'b0;
    misalign_s = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: illegal_s = 1'b0;
      F3_BU, F3_HU:     illegal_s = req_is_store;
      default:          illegal_s = 1'b1;
    endcase
    range_s = ({1'b0, req_addr} >= 33'(DMEM_SIZE_BYTES));
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3)
      F3_H, F3_HU: misalign_s = req_addr[0];
      F3_W:        misalign_s = (req_addr[1:0] != 2'b00);
      default:     misalign_s = 1'b0;
    endcase
`else
    misalign_s = 1'b0;
`endif
  end

  // Fault priority: illegal funct3 > out of range > misaligned
  always_comb begin
    fault = 1'b1;
    cause = CAUSE_NONE;
    if (illegal_s) begin
      cause = CAUSE_ILLEGAL;
    end else if (range_s) begin
      cause = CAUSE_RANGE;
    end else if (misalign_s) begin
      cause = CAUSE_MISALIGN;
    end else begin
      fault = 1'b0;
    end
  end

  // Replicate sub-word store data across all lanes; the cache picks the lane
  always_comb begin
    case (req_funct3)
      F3_B:    store_data = {4{req_wdata[7:0]}};
      F3_H:    store_data = {2{req_wdata[15:0]}};
      default: store_data = req_wdata;
    endcase
  end

  // Pick the addressed byte/half from the read word and extend it
  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte_s = ld_raw[7:0];
      2'd1:    ld_byte_s = ld_raw[15:8];
      2'd2:    ld_byte_s = ld_raw[23:16];
      default: ld_byte_s = ld_raw[31:24];
    endcase
    if (ld_addr_lo[1]) begin
      ld_half_s = ld_raw[31:16];
    end else begin
      ld_half_s = ld_raw[15:0];
    end
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
      F3_BU:   ld_data = {24'h00_0000, ld_byte_s};
      F3_H:    ld_data = {{16{ld_half_s[15]}}, ld_half_s};
      F3_HU:   ld_data = {16'h0000, ld_half_s};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit in front of the data cache.
// One op in flight: IDLE -> ACCESS (address to cache) -> RESP (formatted
// response), with back-to-back acceptance from RESP for 2-cycle throughput.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/W faults).

module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned DMEM_SIZE_BYTES = 32'd65536,
  parameter logic [31:0] RESET_RDATA     = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_is_store,
  input  logic [2:0]                    req_funct3,
  input  logic [31:0]                   req_addr,
  input  logic [31:0]                   req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [31:0]                   resp_rdata,
  output logic                          resp_fault,
  output logic [1:0]                    resp_cause,
  output logic                          cache_d_write_en,
  output logic [`CACHE_D_WRITE_LEN-1:0] cache_d_write,
  output logic [31:0]                   cache_addr,
  output logic [31:0]                   cache_data_to_cache,
  input  logic [31:0]                   cache_data_out
);

  lsu_state_e  state_r;
  lsu_state_e  state_s;
  logic        accept_s;

  logic [31:0] addr_r;
  logic        is_store_r;
  logic [2:0]  funct3_r;
  logic [31:0] wdata_r;
  logic        fault_r;
  logic [1:0]  cause_r;

  logic [31:0] store_data_s;
  logic        fault_s;
  logic [1:0]  cause_s;
  logic [31:0] ld_data_s;

  riscv_lsu_align #(
    .DMEM_SIZE_BYTES(DMEM_SIZE_BYTES)
  ) u_align (
    .req_is_store(req_is_store),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .store_data  (store_data_s),
    .fault       (fault_s),
    .cause       (cause_s),
    .ld_funct3   (funct3_r),
    .ld_addr_lo  (addr_r[1:0]),
    .ld_raw      (cache_data_out),
    .ld_data     (ld_data_s)
  );

  // Ready in IDLE, or in RESP when the response is consumed this cycle
  assign req_ready = (state_r == LSU_IDLE) | ((state_r == LSU_RESP) & resp_ready);
  assign accept_s  = req_valid & req_ready;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      LSU_IDLE: begin
        if (req_valid) begin
          state_s = LSU_ACCESS;
        end else begin
          state_s = LSU_IDLE;
        end
      end
      LSU_ACCESS: state_s = LSU_RESP;
      LSU_RESP: begin
        if (resp_ready & req_valid) begin
          state_s = LSU_ACCESS;
        end else if (resp_ready) begin
          state_s = LSU_IDLE;
        end else begin
          state_s = LSU_RESP;
        end
      end
      default: state_s = LSU_IDLE;
    endcase
  end

  // State register; reset discards any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= LSU_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture the accepted op together with its fault classification
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r     <= 32'h0000_0000;
      is_store_r <= 1'b0;
      funct3_r   <= F3_W;
      wdata_r    <= 32'h0000_0000;
      fault_r    <= 1'b0;
      cause_r    <= CAUSE_NONE;
    end else if (accept_s) begin
      addr_r     <= req_addr;
      is_store_r <= req_is_store;
      funct3_r   <= req_funct3;
      wdata_r    <= store_data_s;
      fault_r    <= fault_s;
      cause_r    <= cause_s;
    end
  end

  // Cache side: write strobe only in ACCESS for a non-faulting store
  assign cache_d_write_en    = (state_r == LSU_ACCESS) & is_store_r & ~fault_r;
  assign cache_d_write       = write_code(funct3_r);
  assign cache_addr          = addr_r;
  assign cache_data_to_cache = wdata_r;

  // Response side: load data only for a non-faulting load in RESP
  always_comb begin
    resp_valid = (state_r == LSU_RESP);
    resp_fault = 1'b0;
    resp_cause = CAUSE_NONE;
    resp_rdata = RESET_RDATA;
    if (resp_valid) begin
      resp_fault = fault_r;
      resp_cause = cause_r;
      if (~is_store_r & ~fault_r) begin
        resp_rdata = ld_data_s;
      end else begin
        resp_rdata = RESET_RDATA;
      end
    end else begin
      resp_rdata = RESET_RDATA;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: table-driven self-checking bench for riscv_lsu with a
// behavioural data RAM (one-cycle read latency, byte-lane writes) and a
// response scoreboard. Honours LSU_MISALIGN_TRAP_EN for expectations.

module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [1:0]  resp_cause;
  logic        cache_d_write_en;
  logic [`CACHE_D_WRITE_LEN-1:0] cache_d_write;
  logic [31:0] cache_addr;
  logic [31:0] cache_data_to_cache;
  logic [31:0] cache_data_out = 32'h0;

  logic        mem_clr = 1'b1;
  logic [31:0] mem [0:16383];

  riscv_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .resp_cause(resp_cause),
    .cache_d_write_en(cache_d_write_en), .cache_d_write(cache_d_write),
    .cache_addr(cache_addr), .cache_data_to_cache(cache_data_to_cache),
    .cache_data_out(cache_data_out)
  );

  always #5 clk = ~clk;

  // Data RAM model: lane writes by code/address, registered read
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
    end else if (cache_d_write_en) begin
      case (cache_d_write)
        `CACHE_D_WRITE_SB: mem[cache_addr[15:2]][{cache_addr[1:0], 3'b000} +: 8] <= cache_data_to_cache[{cache_addr[1:0], 3'b000} +: 8];
        `CACHE_D_WRITE_SH: mem[cache_addr[15:2]][{cache_addr[1], 4'b0000} +: 16] <= cache_data_to_cache[{cache_addr[1], 4'b0000} +: 16];
        default:           mem[cache_addr[15:2]] <= cache_data_to_cache;
      endcase
    end
    cache_data_out <= mem[cache_addr[15:2]];
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  cause;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  cause;
    int          acc_cyc;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          head_seen = 1'b0;
  bit          accepted = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_fault = 1'b0;
  logic [1:0]  exp_cause = 2'b00;

  function automatic vec_t mk(logic st, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, logic fault, logic [1:0] cause);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.fault = fault; v.cause = cause;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Scoreboard side of a cycle: called at the negedge
  task automatic monitor();
    sb_t e;
    accepted = 1'b0;
    if (rst) begin
      sb.delete();
      head_seen = 1'b0;
    end else begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp_valid", {31'h0, resp_valid}, 32'h0);
        end else begin
          if (!head_seen) begin
            check("latency", cyc - sb[0].acc_cyc, 32'd2);
            head_seen = 1'b1;
          end
          if (resp_ready) begin
            e = sb.pop_front();
            head_seen = 1'b0;
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_fault", {31'h0, resp_fault}, {31'h0, e.fault});
            check("resp_cause", {30'h0, resp_cause}, {30'h0, e.cause});
          end
        end
      end
      if (req_valid && req_ready) begin
        e.rdata = exp_rdata; e.fault = exp_fault; e.cause = exp_cause; e.acc_cyc = cyc;
        sb.push_back(e);
        accepted = 1'b1;
      end
    end
  endtask

  // Advance one cycle: sample at negedge, return 1 time unit after posedge
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [`CACHE_D_WRITE_LEN-1:0] exp_code(logic [2:0] f3);
    if (f3 == 3'b000) return `CACHE_D_WRITE_SB;
    else if (f3 == 3'b001) return `CACHE_D_WRITE_SH;
    else return `CACHE_D_WRITE_SW;
  endfunction

  function automatic logic [31:0] exp_rep(logic [2:0] f3, logic [31:0] w);
    if (f3 == 3'b000) return {w[7:0], w[7:0], w[7:0], w[7:0]};
    else if (f3 == 3'b001) return {w[15:0], w[15:0]};
    else return w;
  endfunction

  task automatic drive(input vec_t v);
    req_valid = 1'b1; req_is_store = v.st; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    exp_rdata = v.rdata; exp_fault = v.fault; exp_cause = v.cause;
  endtask

  // One op start to finish with resp_ready held high
  task automatic run_vec(input vec_t v);
    int n;
    logic wr;
    drive(v);
    resp_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!accepted && n < 20);
    check("accept", {31'h0, accepted}, 32'h1);
    req_valid = 1'b0;
    wr = v.st & ~v.fault;
    check("access_write_en", {31'h0, cache_d_write_en}, {31'h0, wr});
    check("access_addr", cache_addr, v.addr);
    if (wr) begin
      check("access_code", {30'h0, cache_d_write}, {30'h0, exp_code(v.f3)});
      check("access_wdata", cache_data_to_cache, exp_rep(v.f3, v.wdata));
    end
    tick();
    check("resp_write_en", {31'h0, cache_d_write_en}, 32'h0);
    n = 0;
    while (sb.size() != 0 && n < 20) begin tick(); n++; end
    check("scoreboard_drained", sb.size(), 32'h0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_fault", {31'h0, resp_fault}, 32'h0);
    check("rst_resp_cause", {30'h0, resp_cause}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_write_en", {31'h0, cache_d_write_en}, 32'h0);
    check("rst_cache_addr", cache_addr, 32'h0);
    check("rst_data_to_cache", cache_data_to_cache, 32'h0);
    check("rst_write_code", {30'h0, cache_d_write}, {30'h0, `CACHE_D_WRITE_SW});
    mem_clr = 1'b0;
    rst = 1'b0;
    tick();

    vecs.push_back(mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2'b00));
    vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2'b00));
    vecs.push_back(mk(1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0, 2'b00));
    vecs.push_back(mk(0, 3'b000, 32'h203, 32'h0, 32'hFFFFFFA5, 0, 2'b00));
    vecs.push_back(mk(0, 3'b100, 32'h203, 32'h0, 32'h000000A5, 0, 2'b00));
    vecs.push_back(mk(1, 3'b010, 32'h100, 32'h80017FFF, 32'h0, 0, 2'b00));
    vecs.push_back(mk(0, 3'b001, 32'h102, 32'h0, 32'hFFFF8001, 0, 2'b00));
    vecs.push_back(mk(0, 3'b101, 32'h102, 32'h0, 32'h00008001, 0, 2'b00));
    vecs.push_back(mk(0, 3'b001, 32'h100, 32'h0, 32'h00007FFF, 0, 2'b00));
    vecs.push_back(mk(0, 3'b000, 32'h101, 32'h0, 32'h0000007F, 0, 2'b00));
    vecs.push_back(mk(0, 3'b100, 32'h103, 32'h0, 32'h00000080, 0, 2'b00));
    vecs.push_back(mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2'b00));
    vecs.push_back(mk(1, 3'b010, 32'h00010100, 32'h11111111, 32'h0, 1, 2'b10));
    vecs.push_back(mk(0, 3'b010, 32'h00010000, 32'h0, 32'h0, 1, 2'b10));
    vecs.push_back(mk(1, 3'b100, 32'h00010100, 32'h22222222, 32'h0, 1, 2'b11));
    vecs.push_back(mk(0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 2'b11));
    vecs.push_back(mk(0, 3'b110, 32'h100, 32'h0, 32'h0, 1, 2'b11));
    vecs.push_back(mk(1, 3'b111, 32'h100, 32'h33333333, 32'h0, 1, 2'b11));
    vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2'b00));
    vecs.push_back(mk(1, 3'b001, 32'h202, 32'hFFFF1234, 32'h0, 0, 2'b00));
    vecs.push_back(mk(0, 3'b101, 32'h202, 32'h0, 32'h00001234, 0, 2'b00));
    vecs.push_back(mk(0, 3'b100, 32'h203, 32'h0, 32'h00000012, 0, 2'b00));
    vecs.push_back(mk(0, 3'b001, 32'h200, 32'h0, 32'h00000000, 0, 2'b00));
    vecs.push_back(mk(0, 3'b010, 32'h00010001, 32'h0, 32'h0, 1, 2'b10));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(1, 3'b010, 32'h101, 32'hCAFEF00D, 32'h0, 1, 2'b01));
    vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2'b00));
    vecs.push_back(mk(0, 3'b001, 32'h103, 32'h0, 32'h0, 1, 2'b01));
    vecs.push_back(mk(0, 3'b101, 32'h101, 32'h0, 32'h0, 1, 2'b01));
    vecs.push_back(mk(0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 2'b01));
    vecs.push_back(mk(1, 3'b001, 32'h203, 32'h5555, 32'h0, 1, 2'b01));
`else
    vecs.push_back(mk(1, 3'b010, 32'h101, 32'hCAFEF00D, 32'h0, 0, 2'b00));
    vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 0, 2'b00));
    vecs.push_back(mk(0, 3'b001, 32'h103, 32'h0, 32'hFFFFCAFE, 0, 2'b00));
    vecs.push_back(mk(0, 3'b101, 32'h101, 32'h0, 32'h0000F00D, 0, 2'b00));
    vecs.push_back(mk(0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0, 2'b00));
    vecs.push_back(mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2'b00));
`endif

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back with a 3-cycle response stall
    drive(mk(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2'b00));
    resp_ready = 1'b0;
    tick();
    check("b2b_first_accept", {31'h0, accepted}, 32'h1);
    drive(mk(0, 3'b010, 32'h200, 32'h0, 32'h12340000, 0, 2'b00));
    #1;
    check("b2b_ready_in_access", {31'h0, req_ready}, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("stall_resp_valid", {31'h0, resp_valid}, 32'h1);
      check("stall_rdata", resp_rdata, 32'hDEADBEEF);
      check("stall_req_ready", {31'h0, req_ready}, 32'h0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("b2b_handshake_ready", {31'h0, req_ready}, 32'h1);
    tick();
    check("b2b_second_accept", {31'h0, accepted}, 32'h1);
    req_valid = 1'b0;
    check("b2b_access_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("b2b_access_addr", cache_addr, 32'h200);
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    check("b2b_drained", sb.size(), 32'h0);
    tick();

    // Reset during the ACCESS cycle of a store
    drive(mk(1, 3'b010, 32'h100, 32'h55555555, 32'h0, 0, 2'b00));
    tick();
    check("rst_op_accept", {31'h0, accepted}, 32'h1);
    req_valid = 1'b0;
    check("rst_op_write_en_before", {31'h0, cache_d_write_en}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_op_write_en_after", {31'h0, cache_d_write_en}, 32'h0);
    check("rst_op_resp_valid", {31'h0, resp_valid}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    run_vec(mk(0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2'b00));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
